// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity selector values and
// line-level bit constants common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel request side and serial line of the UART transmitter.
//
// Handshake: the master raises DATA_Valid with P_DATA/PAR_EN/PAR_TYP/Prescale
// stable; the slave accepts on the first CLK edge where DATA_Valid=1 and
// Busy=0, latching all four. While Busy=1, DATA_Valid is ignored (no queueing).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  import uart_pkg::*;

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  TX_OUT;
  logic                  Busy;
  uart_state_e           state_dbg;

  modport master (
    output P_DATA, DATA_Valid, PAR_EN, PAR_TYP, Prescale,
    input  TX_OUT, Busy, state_dbg
  );

  modport slave (
    input  P_DATA, DATA_Valid, PAR_EN, PAR_TYP, Prescale,
    output TX_OUT, Busy, state_dbg
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..prescale-1, pulses bit_done on the last cycle
// of each bit and counts completed bit periods.
module uart_tx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int CNT_W      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic [CNT_W-1:0]      bit_cnt
);

  logic [PRESCALE_W-1:0] cnt_q;

  // A prescale of 0 wraps to the full counter range, so the frame still ends.
  assign bit_done = en && (cnt_q == (prescale - PRESCALE_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_q   <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (bit_done) begin
        cnt_q   <= '0;
        bit_cnt <= bit_cnt + CNT_W'(1);
      end else begin
        cnt_q   <= cnt_q + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: latches one byte per handshake and sends an LSB-first
// frame (start, data, optional parity, stop) with registered TX_OUT and Busy.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_frame_if.slave bus
);

  localparam int CNT_W = 4;

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  tx_q, tx_d;
  logic                  busy_q;
  logic                  accept;
  logic                  bit_done;
  logic [CNT_W-1:0]      bit_cnt;

  assign accept = (state_q == IDLE) && bus.DATA_Valid && !busy_q;

  uart_tx_bit_timer #(
    .PRESCALE_W (PRESCALE_W),
    .CNT_W      (CNT_W)
  ) u_timer (
    .CLK      (CLK),
    .RST      (RST),
    .en       (state_q != IDLE),
    .clr      (accept),
    .prescale (presc_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  // bit_cnt already counts the start bit, so the last data bit sees DATA_WIDTH.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_cnt == CNT_W'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY:  if (bit_done) state_d = STOP;
      STOP:    if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line value is decided from the next state so TX_OUT can be a plain flop.
  always_comb begin
    tx_d = STOP_BIT;
    case (state_d)
      IDLE:    tx_d = STOP_BIT;
      START:   tx_d = START_BIT;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit_q;
      STOP:    tx_d = STOP_BIT;
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        shift_q   <= bus.P_DATA;
        par_en_q  <= bus.PAR_EN;
        par_bit_q <= (^bus.P_DATA) ^ (bus.PAR_TYP == PAR_ODD);
        presc_q   <= bus.Prescale;
      end else begin
        shift_q   <= shift_d;
      end
    end
  end

  assign bus.TX_OUT    = tx_q;
  assign bus.Busy      = busy_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: framing, parity, handshake rules,
// back-to-back requests and mid-frame reset.
module tb_uart_tx_frame;
  import uart_pkg::*;

  logic CLK;
  logic RST;
  int   vectors;
  int   miscompares;

  uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_W(6)) bus ();

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!RST && bus.DATA_Valid && !bus.Busy && bus.Prescale < 6'd2)
      $error("illegal Prescale %0d requested", bus.Prescale);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_frame(input logic [7:0] data, input logic pe,
                             input logic pt, input logic [5:0] presc);
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Prescale   = presc;
    bus.DATA_Valid = 1'b1;
    tick();
    bus.DATA_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.Busy !== 1'b0 && n < 2000) begin
      tick();
      n++;
    end
    vectors++;
    if (bus.Busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle_timeout: Busy=%b after %0d cycles, required 0", name, bus.Busy, n);
    end
  endtask

  // Samples one frame starting at its first cycle; leaves time at the cycle after it.
  task automatic capture_frame(input int presc, input int nbits,
                               output logic [10:0] obs, output int busy_cnt,
                               output bit stable);
    obs      = '0;
    busy_cnt = 0;
    stable   = 1'b1;
    for (int k = 0; k < nbits; k++) begin
      for (int c = 0; c < presc; c++) begin
        if (c == 0) obs[k] = bus.TX_OUT;
        else if (bus.TX_OUT !== obs[k]) stable = 1'b0;
        if (bus.Busy === 1'b1) busy_cnt++;
        tick();
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1;
    repeat (3) tick();
    vectors++;
    if (bus.TX_OUT !== 1'b1) begin
      miscompares++; $display("FAIL reset_tx: got %b expected 1", bus.TX_OUT);
    end
    vectors++;
    if (bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.Busy);
    end
    vectors++;
    if (bus.state_dbg !== IDLE) begin
      miscompares++; $display("FAIL reset_state: got %0d expected %0d", bus.state_dbg, IDLE);
    end
    // Request coinciding with reset must be dropped.
    bus.P_DATA     = 8'hA5;
    bus.DATA_Valid = 1'b1;
    tick();
    RST            = 1'b0;
    bus.DATA_Valid = 1'b0;
    tick();
    vectors++;
    if (bus.Busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_wins: Busy=%b TX=%b expected Busy=0 TX=1", bus.Busy, bus.TX_OUT);
    end
  endtask

  task automatic test_no_parity();
    logic [10:0] obs;
    int          bc;
    bit          st;
    wait_idle("no_parity");
    start_frame(8'hA5, 1'b0, PAR_EVEN, 6'd8);
    vectors++;
    if (bus.TX_OUT !== 1'b0 || bus.Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL latency: TX=%b Busy=%b expected TX=0 Busy=1", bus.TX_OUT, bus.Busy);
    end
    capture_frame(8, 10, obs, bc, st);
    vectors++;
    if (obs !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
      miscompares++; $display("FAIL a5_bits: got %h expected %h", obs, {1'b0, 1'b1, 8'hA5, 1'b0});
    end
    vectors++;
    if (bc !== 80 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL a5_busy: got %0d cycles, Busy after=%b, expected 80 and 0", bc, bus.Busy);
    end
    vectors++;
    if (!st) begin
      miscompares++; $display("FAIL a5_bit_width: got unstable bit, expected 8-cycle bits");
    end
  endtask

  task automatic test_parity_16();
    logic [10:0] obs;
    int          bc;
    bit          st;
    wait_idle("parity_even16");
    start_frame(8'hA5, 1'b1, PAR_EVEN, 6'd16);
    capture_frame(16, 11, obs, bc, st);
    vectors++;
    if (obs !== {1'b1, 1'b0, 8'hA5, 1'b0} || !st) begin
      miscompares++; $display("FAIL even16_bits: got %h stable=%b expected %h", obs, st, {1'b1, 1'b0, 8'hA5, 1'b0});
    end
    vectors++;
    if (bc !== 176 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL even16_len: got %0d expected 176", bc);
    end
    wait_idle("parity_odd16");
    start_frame(8'hA5, 1'b1, PAR_ODD, 6'd16);
    capture_frame(16, 11, obs, bc, st);
    vectors++;
    if (obs !== {1'b1, 1'b1, 8'hA5, 1'b0} || !st) begin
      miscompares++; $display("FAIL odd16_bits: got %h stable=%b expected %h", obs, st, {1'b1, 1'b1, 8'hA5, 1'b0});
    end
  endtask

  task automatic test_parity_edges();
    logic [10:0] obs;
    int          bc;
    bit          st;
    wait_idle("odd_00");
    start_frame(8'h00, 1'b1, PAR_ODD, 6'd8);
    capture_frame(8, 11, obs, bc, st);
    vectors++;
    if (obs !== {1'b1, 1'b1, 8'h00, 1'b0} || bc !== 88) begin
      miscompares++; $display("FAIL odd_00: got %h len %0d expected %h len 88", obs, bc, {1'b1, 1'b1, 8'h00, 1'b0});
    end
    wait_idle("even_ff");
    start_frame(8'hFF, 1'b1, PAR_EVEN, 6'd8);
    capture_frame(8, 11, obs, bc, st);
    vectors++;
    if (obs !== {1'b1, 1'b0, 8'hFF, 1'b0} || bc !== 88) begin
      miscompares++; $display("FAIL even_ff: got %h len %0d expected %h len 88", obs, bc, {1'b1, 1'b0, 8'hFF, 1'b0});
    end
  endtask

  task automatic test_ignore_midframe();
    logic [10:0] obs;
    int          bc;
    bit          st;
    int          extra;
    wait_idle("ignore");
    start_frame(8'hA5, 1'b0, PAR_EVEN, 6'd8);
    fork
      capture_frame(8, 10, obs, bc, st);
      begin
        repeat (20) tick();
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b1;
        bus.Prescale   = 6'd16;
        bus.DATA_Valid = 1'b1;
        tick();
        bus.DATA_Valid = 1'b0;
      end
    join
    vectors++;
    if (obs !== {1'b0, 1'b1, 8'hA5, 1'b0} || bc !== 80 || !st) begin
      miscompares++; $display("FAIL ignore_frame: got %h len %0d expected %h len 80", obs, bc, {1'b0, 1'b1, 8'hA5, 1'b0});
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) extra++;
      tick();
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++; $display("FAIL ignore_no_queue: got %0d active cycles expected 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] obs;
    int          bc;
    bit          st;
    wait_idle("b2b");
    bus.P_DATA     = 8'h55;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = PAR_EVEN;
    bus.Prescale   = 6'd8;
    bus.DATA_Valid = 1'b1;
    tick();
    bus.P_DATA = 8'hAA;
    capture_frame(8, 10, obs, bc, st);
    vectors++;
    if (obs !== {1'b0, 1'b1, 8'h55, 1'b0} || bc !== 80 || !st) begin
      miscompares++; $display("FAIL b2b_first: got %h len %0d expected %h len 80", obs, bc, {1'b0, 1'b1, 8'h55, 1'b0});
    end
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL b2b_gap: TX=%b Busy=%b expected TX=1 Busy=0", bus.TX_OUT, bus.Busy);
    end
    tick();
    bus.DATA_Valid = 1'b0;
    capture_frame(8, 10, obs, bc, st);
    vectors++;
    if (obs !== {1'b0, 1'b1, 8'hAA, 1'b0} || bc !== 80 || !st) begin
      miscompares++; $display("FAIL b2b_second: got %h len %0d expected %h len 80", obs, bc, {1'b0, 1'b1, 8'hAA, 1'b0});
    end
  endtask

  task automatic test_reset_midframe();
    logic [10:0] obs;
    int          bc;
    bit          st;
    wait_idle("rst_mid");
    start_frame(8'hA5, 1'b0, PAR_EVEN, 6'd8);
    repeat (4 * 8 + 3) tick();
    vectors++;
    if (bus.TX_OUT !== 1'b0 || bus.state_dbg !== DATA) begin
      miscompares++; $display("FAIL rst_mid_pre: TX=%b state=%0d expected 0 and DATA", bus.TX_OUT, bus.state_dbg);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vectors++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_abort: TX=%b Busy=%b expected TX=1 Busy=0", bus.TX_OUT, bus.Busy);
    end
    start_frame(8'h3C, 1'b1, PAR_ODD, 6'd8);
    capture_frame(8, 11, obs, bc, st);
    vectors++;
    if (obs !== {1'b1, 1'b1, 8'h3C, 1'b0} || bc !== 88 || !st) begin
      miscompares++; $display("FAIL rst_mid_after: got %h len %0d expected %h len 88", obs, bc, {1'b1, 1'b1, 8'h3C, 1'b0});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors        = 0;
    miscompares    = 0;
    RST            = 1'b1;
    bus.P_DATA     = '0;
    bus.DATA_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = PAR_EVEN;
    bus.Prescale   = 6'd8;

    test_reset();
    test_no_parity();
    test_parity_16();
    test_parity_edges();
    test_ignore_midframe();
    test_back_to_back();
    test_reset_midframe();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial transmitter that pairs with the team's UART receiver on the same link.
- Accepts one parallel byte per handshake and emits an LSB-first frame on TX_OUT: start bit, 8 data bits, an optional parity bit, and one stop bit.
- Each bit lasts Prescale CLK cycles, matching the receiver's oversampling setting, so one Prescale value configures both ends.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of the Prescale input and of the bit-period counter.

Ports:
- CLK  input  1  system clock; single clock domain.
- RST  input  1  reset, synchronous and active-high.
- P_DATA  input  DATA_WIDTH  byte to transmit; valid when DATA_Valid=1.
- DATA_Valid  input  1  request to transmit P_DATA.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16, 32.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in flight.

Behaviour:
- Reset (RST=1 at a CLK edge): state IDLE, TX_OUT=1, Busy=0, all counters 0. Reset mid-frame aborts the frame; the line returns high on the next cycle.
- All outputs are registered. No combinational path from inputs to TX_OUT or Busy.
- Handshake:
  - The request is accepted only in IDLE, on the edge where DATA_Valid=1 and Busy=0.
  - On acceptance, P_DATA, PAR_EN, PAR_TYP and Prescale are latched. Input changes during a frame have no effect.
  - DATA_Valid while Busy=1 is ignored and not queued.
- Latency: request accepted at edge N → TX_OUT=0 and Busy=1 from cycle N+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TX_OUT=1. Goes to START on acceptance.
  - START: TX_OUT=0 for Prescale cycles, then DATA.
  - DATA: TX_OUT = shift register bit 0, LSB first. The register shifts after each Prescale-cycle bit period. After bit 7 → PARITY if PAR_EN is latched, else STOP.
  - PARITY: TX_OUT = parity bit for Prescale cycles, then STOP.
  - STOP: TX_OUT=1 for Prescale cycles, then IDLE. Busy drops on the same edge.
- Bit timer:
  - Counts 0..Prescale-1 and wraps to 0 at the end of each bit.
  - bit_cnt advances on each wrap and resets to 0 when START is entered.
- Parity:
  - Computed once at acceptance as XOR of the 8 data bits, then XOR with PAR_TYP.
  - Even parity: total count of ones (data plus parity) is even. Odd parity: total is odd.
- Frame length: Prescale*10 cycles without parity, Prescale*11 with parity.
- Back-to-back: a request held high is accepted in the first IDLE cycle after STOP. This gives at least one extra high cycle between frames.
- Prescale values below 2 are illegal; behaviour is then unspecified but must not hang the FSM beyond one frame. The verifier flags such values with an assertion.
- Simultaneous RST and DATA_Valid: reset wins and the request is dropped.

Decomposition:
- Shared package uart_pkg holds:
  - the state encodings (IDLE/START/DATA/PARITY/STOP) and the PAR_EVEN/PAR_ODD constants, also used by the receiver;
  - the START_BIT=0 and STOP_BIT=1 constants.
- One sub-module, uart_tx_bit_timer: a Prescale-cycle counter that outputs a one-cycle bit_done pulse and counts bits. Enabled while Busy, cleared on acceptance.

Test Plan:
- Prescale=8, PAR_EN=0, P_DATA=0xA5:
  - Busy high exactly 80 cycles.
  - TX_OUT sequence 0,1,0,1,0,0,1,0,1,1, each bit 8 cycles.
- Prescale=16, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5:
  - Parity bit = 0; frame is 176 cycles.
  - Repeat with PAR_TYP=1 → parity bit = 1.
- Prescale=8, PAR_EN=1, PAR_TYP=1, P_DATA=0x00 → parity bit = 1. P_DATA=0xFF with even parity → parity bit = 0.
- DATA_Valid pulsed with P_DATA=0x3C mid-frame:
  - Ignored; current frame completes unchanged.
  - No second frame follows; TX_OUT stays 1.
- DATA_Valid held high with 0x55 then 0xAA:
  - Two complete frames.
  - Gap of at least 1 high cycle between the end of the first stop bit and the second start bit.
- RST asserted during DATA bit 3 → next cycle TX_OUT=1, Busy=0. A new request after reset sends a full, correct frame.
